// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared geometry constants and FSM state type for conv_window_reader
package conv_pkg;
    localparam int IMG_W     = 4;
    localparam int IMG_H     = 4;
    localparam int K         = 3;
    localparam int DATA_W    = 8;
    localparam int OUT_W     = IMG_W - K + 1;
    localparam int OUT_H     = IMG_H - K + 1;
    localparam int ACC_W     = 2 * DATA_W + 4;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int NTAP      = K * K;
    localparam int NWIN      = OUT_W * OUT_H;
    localparam int PIX_IDX_W = $clog2(NPIX);
    localparam int TAP_W     = $clog2(NTAP);
    localparam int WIN_W     = $clog2(NWIN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/conv_tap_addr_gen.sv
// rtl/conv_tap_addr_gen.sv - maps (window, tap) to image byte index and filter index
module conv_tap_addr_gen
    import conv_pkg::*;
(
    input  logic [WIN_W-1:0]     win_i,
    input  logic [TAP_W-1:0]     tap_i,
    output logic [PIX_IDX_W-1:0] pix_idx_o,
    output logic [TAP_W-1:0]     flt_idx_o
);
    int w;
    int t;
    int row;
    int col;

    always_comb begin
        w         = int'(win_i);
        t         = int'(tap_i);
        row       = (w / OUT_W) + (t / K);
        col       = (w % OUT_W) + (t % K);
        pix_idx_o = PIX_IDX_W'(row * IMG_W + col);
        flt_idx_o = tap_i;
    end
endmodule

// File: rtl/conv_window_reader.sv
// rtl/conv_window_reader.sv - snapshots image/filter and streams every 3x3 window tap to the MAC
// Optional accumulator outputs acc_valid/acc_data enabled by CONV_WINDOW_ACC_EN.
module conv_window_reader
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NPIX*DATA_W-1:0]   img_flat,
    input  logic [NTAP*DATA_W-1:0]   flt_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pix,
    output logic [DATA_W-1:0]        out_wgt,
    output logic                     out_last_tap,
    output logic [WIN_W-1:0]         out_win,
    output logic                     busy,
    output logic                     done
`ifdef CONV_WINDOW_ACC_EN
    ,
    output logic                     acc_valid,
    output logic [ACC_W-1:0]         acc_data
`endif
);
    state_t                   state_q, state_d;
    logic [NPIX*DATA_W-1:0]   img_q, img_d, src_img;
    logic [NTAP*DATA_W-1:0]   flt_q, flt_d, src_flt;
    logic [WIN_W-1:0]         win_q, win_d, owin_q, owin_d;
    logic [TAP_W-1:0]         tap_q, tap_d, flt_idx;
    logic [PIX_IDX_W-1:0]     pix_idx;
    logic [DATA_W-1:0]        pix_q, pix_d, wgt_q, wgt_d;
    logic                     last_q, last_d;
    logic                     load;
    logic                     hs;

    assign hs = (state_q == STREAM) && out_ready;

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        flt_d   = flt_q;
        win_d   = win_q;
        tap_d   = tap_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    img_d   = img_flat;
                    flt_d   = flt_flat;
                    win_d   = '0;
                    tap_d   = '0;
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (tap_q == TAP_W'(NTAP - 1)) begin
                        tap_d = '0;
                        if (win_q == WIN_W'(NWIN - 1)) begin
                            state_d = DONE;
                        end else begin
                            win_d = win_q + WIN_W'(1);
                            load  = 1'b1;
                        end
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first beat of a pass must come from the live inputs: the snapshot lands on the same edge.
    assign src_img = (state_q == IDLE) ? img_flat : img_q;
    assign src_flt = (state_q == IDLE) ? flt_flat : flt_q;

    conv_tap_addr_gen u_addr (
        .win_i     (win_d),
        .tap_i     (tap_d),
        .pix_idx_o (pix_idx),
        .flt_idx_o (flt_idx)
    );

    always_comb begin
        pix_d  = pix_q;
        wgt_d  = wgt_q;
        last_d = last_q;
        owin_d = owin_q;
        if (load) begin
            pix_d  = src_img[int'(pix_idx)*DATA_W +: DATA_W];
            wgt_d  = src_flt[int'(flt_idx)*DATA_W +: DATA_W];
            last_d = (tap_d == TAP_W'(NTAP - 1));
            owin_d = win_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            img_q   <= '0;
            flt_q   <= '0;
            win_q   <= '0;
            tap_q   <= '0;
            pix_q   <= '0;
            wgt_q   <= '0;
            last_q  <= 1'b0;
            owin_q  <= '0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            flt_q   <= flt_d;
            win_q   <= win_d;
            tap_q   <= tap_d;
            pix_q   <= pix_d;
            wgt_q   <= wgt_d;
            last_q  <= last_d;
            owin_q  <= owin_d;
        end
    end

    assign out_valid    = (state_q == STREAM);
    assign busy         = (state_q == STREAM);
    assign done         = (state_q == DONE);
    assign out_pix      = pix_q;
    assign out_wgt      = wgt_q;
    assign out_last_tap = last_q;
    assign out_win      = owin_q;

`ifdef CONV_WINDOW_ACC_EN
    logic [ACC_W-1:0] prod, sum_q, sum_d, acc_data_q;
    logic             acc_valid_q;

    assign prod = ACC_W'(pix_q) * ACC_W'(wgt_q);

    // Tap 0 restarts the running sum so the previous window's result stays on acc_data.
    always_comb begin
        sum_d = sum_q;
        if (hs) begin
            sum_d = (tap_q == '0) ? prod : sum_q + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
        end else begin
            sum_q       <= sum_d;
            acc_valid_q <= hs && last_q;
            if (hs && last_q) begin
                acc_data_q <= sum_d;
            end
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_data  = acc_data_q;
`endif
endmodule

// File: tb/tb_conv_window_reader.sv
// tb/tb_conv_window_reader.sv - randomized self-checking bench for conv_window_reader
module tb_conv_window_reader;
    import conv_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [NPIX*DATA_W-1:0] img_flat;
    logic [NTAP*DATA_W-1:0] flt_flat;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_pix;
    logic [DATA_W-1:0]      out_wgt;
    logic                   out_last_tap;
    logic [WIN_W-1:0]       out_win;
    logic                   busy;
    logic                   done;
`ifdef CONV_WINDOW_ACC_EN
    logic                   acc_valid;
    logic [ACC_W-1:0]       acc_data;
`endif

    int checks = 0;
    int errors = 0;
    int ref_img[NPIX];
    int ref_flt[NTAP];
    int fix_img[NPIX] = '{137,139,1,162, 36,206,231,205, 13,154,102,209, 122,40,57,200};
    int fix_flt[NTAP] = '{165,213,198, 124,79,77, 111,172,162};

    conv_window_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .img_flat     (img_flat),
        .flt_flat     (flt_flat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pix      (out_pix),
        .out_wgt      (out_wgt),
        .out_last_tap (out_last_tap),
        .out_win      (out_win),
        .busy         (busy),
        .done         (done)
`ifdef CONV_WINDOW_ACC_EN
        ,
        .acc_valid    (acc_valid),
        .acc_data     (acc_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_data(input bit rnd);
        for (int i = 0; i < NPIX; i++) begin
            ref_img[i] = rnd ? int'($urandom_range(255)) : fix_img[i];
            img_flat[i*DATA_W +: DATA_W] = DATA_W'(ref_img[i]);
        end
        for (int i = 0; i < NTAP; i++) begin
            ref_flt[i] = rnd ? int'($urandom_range(255)) : fix_flt[i];
            flt_flat[i*DATA_W +: DATA_W] = DATA_W'(ref_flt[i]);
        end
    endtask

    // Beat b of a pass: window b/NTAP, tap b%NTAP, straight from the convolution definition.
    function automatic int exp_pix(input int b);
        int w = b / NTAP;
        int t = b % NTAP;
        return ref_img[(w / OUT_W + t / K) * IMG_W + (w % OUT_W) + (t % K)];
    endfunction

    function automatic int exp_wgt(input int b);
        return ref_flt[b % NTAP];
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; img_flat = '0; flt_flat = '0;
        #12;
        checks++;
        if ({out_valid, out_pix, out_wgt, out_last_tap, out_win, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {out_valid, out_pix, out_wgt, out_last_tap, out_win, busy, done});
        end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_stream(input bit rnd, input int ready_pct, input bit mutate);
        int beats = 0;
        int cyc = 0;
        load_data(rnd);
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid got=%b want=1", out_valid);
        end
        while (beats < NWIN * NTAP && cyc < 2000) begin
            start = 1'b0;
            if (mutate && beats >= 10 && beats < 12) begin
                start = 1'b1;
                img_flat = ~img_flat;
                flt_flat = ~flt_flat;
            end
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL stream_ctl beat=%0d got v/b/d=%b%b%b want=110", beats, out_valid, busy, done);
            end
            checks++;
            if (out_pix !== DATA_W'(exp_pix(beats)) || out_wgt !== DATA_W'(exp_wgt(beats))) begin
                errors++;
                $display("FAIL stream_data beat=%0d got pix=%0d wgt=%0d want pix=%0d wgt=%0d",
                         beats, out_pix, out_wgt, exp_pix(beats), exp_wgt(beats));
            end
            checks++;
            if (out_last_tap !== (beats % NTAP == NTAP - 1) || out_win !== WIN_W'(beats / NTAP)) begin
                errors++;
                $display("FAIL stream_tag beat=%0d got last=%b win=%0d want last=%b win=%0d", beats,
                         out_last_tap, out_win, (beats % NTAP == NTAP - 1), beats / NTAP);
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_ready) beats++;
            tick;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (beats != NWIN * NTAP || (ready_pct >= 100 && cyc != NWIN * NTAP)) begin
            errors++;
            $display("FAIL beat_count got beats=%0d cycles=%0d want 36", beats, cyc);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got d/b/v=%b%b%b want=100", done, busy, out_valid);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width got d/b=%b%b want=00", done, busy);
        end
    endtask

    task automatic test_stall;
        int beats = 0;
        int cyc = 0;
        load_data(1'b0);
        start = 1'b1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        while (beats < NWIN * NTAP && cyc < 200) begin
            if (beats == 4 && out_ready) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick;
                    cyc++;
                    checks++;
                    if (out_valid !== 1'b1 || out_pix !== 8'd206 || out_wgt !== 8'd79 ||
                        out_win !== 2'd0 || out_last_tap !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d got v=%b pix=%0d wgt=%0d want v=1 pix=206 wgt=79",
                                 s, out_valid, out_pix, out_wgt);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_pix !== DATA_W'(exp_pix(beats)) || out_wgt !== DATA_W'(exp_wgt(beats))) begin
                errors++;
                $display("FAIL stall_data beat=%0d got pix=%0d wgt=%0d want pix=%0d wgt=%0d",
                         beats, out_pix, out_wgt, exp_pix(beats), exp_wgt(beats));
            end
            beats++;
            tick;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done got=%b want=1", done);
        end
        tick;
    endtask

    task automatic test_rst_mid;
        int saw_done = 0;
        load_data(1'b0);
        start = 1'b1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        for (int b = 0; b < 20; b++) tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_pix, out_wgt, out_last_tap, out_win, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h want=0",
                     {out_valid, out_pix, out_wgt, out_last_tap, out_win, busy, done});
        end
        for (int c = 0; c < 4; c++) begin
            tick;
            if (done) saw_done++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (done) saw_done++;
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got=%0d pulses want=0", saw_done);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 8'd137 || out_wgt !== 8'd165) begin
            errors++;
            $display("FAIL rst_restart got v=%b pix=%0d wgt=%0d want v=1 pix=137 wgt=165",
                     out_valid, out_pix, out_wgt);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_done_start;
        int cyc = 0;
        load_data(1'b1);
        start = 1'b1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        while (!done && cyc < 200) begin
            tick;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ds_reach_done got=%b want=1", done);
        end
        start = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ds_ignored got b/v/d=%b%b%b want=000", busy, out_valid, done);
        end
        tick;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== DATA_W'(exp_pix(0))) begin
            errors++;
            $display("FAIL ds_accepted got v=%b pix=%0d want v=1 pix=%0d", out_valid, out_pix, exp_pix(0));
        end
        cyc = 0;
        while (!done && cyc < 200) begin
            tick;
            cyc++;
        end
        tick;
    endtask

`ifdef CONV_WINDOW_ACC_EN
    task automatic test_acc;
        int beats = 0;
        int cyc = 0;
        int pend = -1;
        int sum;
        load_data(1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        while (beats < NWIN * NTAP && cyc < 2000) begin
            checks++;
            if (pend >= 0) begin
                sum = 0;
                for (int t = 0; t < NTAP; t++) sum += exp_pix(pend * NTAP + t) * exp_wgt(pend * NTAP + t);
                if (acc_valid !== 1'b1 || acc_data !== ACC_W'(sum) || (pend == 0 && acc_data !== 20'd135390)) begin
                    errors++;
                    $display("FAIL acc_window win=%0d got v=%b data=%0d want v=1 data=%0d",
                             pend, acc_valid, acc_data, sum);
                end
            end else if (acc_valid !== 1'b0) begin
                errors++;
                $display("FAIL acc_spurious beat=%0d got=%b want=0", beats, acc_valid);
            end
            out_ready = ($urandom_range(99) < 60);
            pend = -1;
            if (out_ready) begin
                if (beats % NTAP == NTAP - 1) pend = beats / NTAP;
                beats++;
            end
            tick;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        sum = 0;
        for (int t = 0; t < NTAP; t++) sum += exp_pix(3 * NTAP + t) * exp_wgt(3 * NTAP + t);
        if (acc_valid !== 1'b1 || acc_data !== ACC_W'(sum)) begin
            errors++;
            $display("FAIL acc_last got v=%b data=%0d want v=1 data=%0d", acc_valid, acc_data, sum);
        end
        tick;
        checks++;
        if (acc_valid !== 1'b0 || acc_data !== ACC_W'(sum)) begin
            errors++;
            $display("FAIL acc_hold got v=%b data=%0d want v=0 data=%0d", acc_valid, acc_data, sum);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_stream(1'b0, 100, 1'b0);
        test_stream(1'b1, 100, 1'b0);
        test_stream(1'b1, 50, 1'b0);
        test_stream(1'b0, 70, 1'b1);
        test_stall;
        test_rst_mid;
        test_done_start;
`ifdef CONV_WINDOW_ACC_EN
        test_acc;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
